// File: rtl/alu_ctrl_pkg.sv
// Shared types, ALU opcodes and helpers for the ALU operand-stack sequencer.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      KIND_PUSH = 2'b00,
      KIND_POP  = 2'b01,
      KIND_EXEC = 2'b10,
      KIND_RSVD = 2'b11
   } cmd_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_BLT = 3'b001;
   localparam logic [2:0] OP_LDI = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_ABS = 3'b111;

   localparam int unsigned CNT_W = 4;

   // Register-only opcodes never read or write the operand stack.
   function automatic logic uses_stack(input logic [2:0] op);
      return !((op == OP_LDI) || (op == OP_ABS));
   endfunction

endpackage

// File: rtl/alu_stack_ctrl_if.sv
// Command/response handshake plus ALU operand/result bus of the stack sequencer.
interface alu_stack_ctrl_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
);
   import alu_ctrl_pkg::*;

   localparam int unsigned DW = $clog2(DEPTH + 1);

   logic          cmd_valid;
   logic          cmd_ready;
   cmd_kind_t     cmd_kind;
   logic [2:0]    cmd_op;
   logic [W-1:0]  cmd_data;
   logic          rsp_valid;
   logic [W-1:0]  rsp_data;
   logic          rsp_branch;
   logic          rsp_err;
   logic [DW-1:0] depth;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_reg_val;
   logic [W-1:0]  alu_stack0;
   logic [W-1:0]  alu_stack1;
   logic [W-1:0]  alu_reg_out;
   logic [W-1:0]  alu_stack0_out;
   logic [W-1:0]  alu_stack1_out;
   logic          alu_branch_sig;

   // Decode and ALU side.
   modport master (
      output cmd_valid, cmd_kind, cmd_op, cmd_data,
      output alu_reg_out, alu_stack0_out, alu_stack1_out, alu_branch_sig,
      input  cmd_ready, rsp_valid, rsp_data, rsp_branch, rsp_err, depth,
      input  alu_op, alu_reg_val, alu_stack0, alu_stack1
   );

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_kind, cmd_op, cmd_data,
      input  alu_reg_out, alu_stack0_out, alu_stack1_out, alu_branch_sig,
      output cmd_ready, rsp_valid, rsp_data, rsp_branch, rsp_err, depth,
      output alu_op, alu_reg_val, alu_stack0, alu_stack1
   );

endinterface

// File: rtl/op_stack.sv
// LIFO operand storage: push, pop, and in-place rewrite of the top two entries.
module op_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [W-1:0]                 push_data_i,
   input  logic                         pop_i,
   input  logic                         wr2_i,
   input  logic [W-1:0]                 top_wdata_i,
   input  logic [W-1:0]                 next_wdata_i,
   output logic [W-1:0]                 top_o,
   output logic [W-1:0]                 next_o,
   output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [DW-1:0] depth_q;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] top_idx;
   logic [IW-1:0] next_idx;

   assign wr_idx   = IW'(depth_q);
   assign top_idx  = IW'(depth_q - DW'(1));
   assign next_idx = IW'(depth_q - DW'(2));

   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= '0;
      end else if (push_i) begin
         depth_q <= depth_q + DW'(1);
      end else if (pop_i) begin
         depth_q <= depth_q - DW'(1);
      end
   end

   // Storage contents are don't-care after reset; only depth_q is cleared.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_idx] <= push_data_i;
      end else if (wr2_i) begin
         mem_q[top_idx]  <= top_wdata_i;
         mem_q[next_idx] <= next_wdata_i;
      end
   end

   assign top_o   = (depth_q != '0)      ? mem_q[top_idx]  : '0;
   assign next_o  = (depth_q >= DW'(2))  ? mem_q[next_idx] : '0;
   assign depth_o = depth_q;

endmodule

// File: rtl/alu_stack_ctrl.sv
// Sequencer owning the ALU operand stack: accepts PUSH/POP/EXEC, drives the ALU, writes back results.
module alu_stack_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_stack_ctrl_if.slave       bus
);

   localparam int unsigned DW = $clog2(DEPTH + 1);

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [W-1:0]       data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [W-1:0]       rsp_data_q, rsp_data_d;
   logic               rsp_branch_q, rsp_branch_d;
   logic               rsp_err_q, rsp_err_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic [W-1:0]       alu_reg_val_q, alu_reg_val_d;
   logic [W-1:0]       alu_stack0_q, alu_stack0_d;
   logic [W-1:0]       alu_stack1_q, alu_stack1_d;

   logic               push_c, pop_c, wr2_c;
   logic [W-1:0]       top_c, next_c;
   logic [DW-1:0]      depth_c;

   op_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push_c),
      .push_data_i  (bus.cmd_data),
      .pop_i        (pop_c),
      .wr2_i        (wr2_c),
      .top_wdata_i  (bus.alu_stack0_out),
      .next_wdata_i (bus.alu_stack1_out),
      .top_o        (top_c),
      .next_o       (next_c),
      .depth_o      (depth_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         data_q        <= '0;
         cnt_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_branch_q  <= 1'b0;
         rsp_err_q     <= 1'b0;
         alu_op_q      <= '0;
         alu_reg_val_q <= '0;
         alu_stack0_q  <= '0;
         alu_stack1_q  <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         data_q        <= data_d;
         cnt_q         <= cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_branch_q  <= rsp_branch_d;
         rsp_err_q     <= rsp_err_d;
         alu_op_q      <= alu_op_d;
         alu_reg_val_q <= alu_reg_val_d;
         alu_stack0_q  <= alu_stack0_d;
         alu_stack1_q  <= alu_stack1_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      data_d        = data_q;
      cnt_d         = cnt_q;
      rsp_data_d    = rsp_data_q;
      rsp_branch_d  = rsp_branch_q;
      rsp_err_d     = rsp_err_q;
      alu_op_d      = alu_op_q;
      alu_reg_val_d = alu_reg_val_q;
      alu_stack0_d  = alu_stack0_q;
      alu_stack1_d  = alu_stack1_q;
      push_c        = 1'b0;
      pop_c         = 1'b0;
      wr2_c         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               op_d         = bus.cmd_op;
               data_d       = bus.cmd_data;
               rsp_data_d   = '0;
               rsp_branch_d = 1'b0;
               rsp_err_d    = 1'b0;
               state_d      = ST_DONE;
               case (bus.cmd_kind)
                  KIND_PUSH: begin
                     if (depth_c < DW'(DEPTH)) push_c = 1'b1;
                     else                      rsp_err_d = 1'b1;
                  end
                  KIND_POP: begin
                     if (depth_c != '0) begin
                        pop_c      = 1'b1;
                        rsp_data_d = top_c;
                     end else begin
                        rsp_err_d  = 1'b1;
                     end
                  end
                  KIND_EXEC: begin
                     // Stack ops need two operands; reject without touching the ALU.
                     if (uses_stack(bus.cmd_op) && (depth_c < DW'(2))) rsp_err_d = 1'b1;
                     else                                               state_d   = ST_ISSUE;
                  end
                  default: rsp_err_d = 1'b1;
               endcase
            end
         end
         ST_ISSUE: begin
            alu_op_d      = op_q;
            alu_reg_val_d = data_q;
            if (uses_stack(op_q)) begin
               alu_stack0_d = top_c;
               alu_stack1_d = next_c;
            end
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               rsp_data_d   = bus.alu_reg_out;
               rsp_branch_d = bus.alu_branch_sig & (op_q == OP_BLT);
               wr2_c        = uses_stack(op_q);
               state_d      = ST_DONE;
            end
         end
         ST_DONE: begin
            rsp_data_d   = '0;
            rsp_branch_d = 1'b0;
            rsp_err_d    = 1'b0;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      rsp_valid_d = (state_d == ST_DONE);
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_branch  = rsp_branch_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.depth       = depth_c;
   assign bus.alu_op      = alu_op_q;
   assign bus.alu_reg_val = alu_reg_val_q;
   assign bus.alu_stack0  = alu_stack0_q;
   assign bus.alu_stack1  = alu_stack1_q;

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Directed bench for alu_stack_ctrl with a combinational add/compare ALU stub (ALU_LAT=1).
module tb_alu_stack_ctrl;
   import alu_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   // Results of the last do_cmd call.
   int         r_lat;
   logic       r_rdy;
   logic [7:0] r_data;
   logic       r_branch;
   logic       r_err;
   logic [2:0] s_op;
   logic [7:0] s_rv, s_s0, s_s1;
   logic       r_cleared;

   alu_stack_ctrl_if #(.W(8), .DEPTH(8)) bus ();

   alu_stack_ctrl #(.W(8), .DEPTH(8), .ALU_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.alu_reg_out    = bus.alu_stack0 + bus.alu_stack1;
   assign bus.alu_stack0_out = bus.alu_stack0 + bus.alu_stack1;
   assign bus.alu_stack1_out = bus.alu_stack1;
   assign bus.alu_branch_sig = (bus.alu_stack0 < bus.alu_stack1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one command and follow it to its response (bounded to 20 cycles).
   task automatic do_cmd(input cmd_kind_t k, input logic [2:0] op, input logic [7:0] d);
      @(negedge clk);
      r_rdy         = bus.cmd_ready;
      bus.cmd_valid = 1'b1;
      bus.cmd_kind  = k;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      r_lat    = 0;
      r_data   = 8'hxx;
      r_branch = 1'bx;
      r_err    = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) begin
            s_op = bus.alu_op; s_rv = bus.alu_reg_val;
            s_s0 = bus.alu_stack0; s_s1 = bus.alu_stack1;
         end
         if (bus.rsp_valid) begin
            r_lat = c; r_data = bus.rsp_data; r_branch = bus.rsp_branch; r_err = bus.rsp_err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      r_cleared = !bus.rsp_valid && (bus.rsp_data == 8'd0) && !bus.rsp_branch && !bus.rsp_err
                  && bus.cmd_ready;
   endtask

   task automatic test_reset();
      total_cnt++;
      if ((bus.cmd_ready !== 1'b1) || (bus.depth !== 4'd0) || (bus.rsp_valid !== 1'b0)
          || (bus.rsp_data !== 8'd0) || (bus.rsp_err !== 1'b0) || (bus.rsp_branch !== 1'b0)) begin
         $display("FAIL reset_outputs: ready=%b depth=%0d rsp_valid=%b data=%0d err=%b br=%b, required 1/0/0/0/0/0",
                  bus.cmd_ready, bus.depth, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_branch);
      end else pass_cnt++;
      total_cnt++;
      if ((bus.alu_op !== 3'd0) || (bus.alu_reg_val !== 8'd0) || (bus.alu_stack0 !== 8'd0)
          || (bus.alu_stack1 !== 8'd0)) begin
         $display("FAIL reset_alu: op=%0d rv=%0d s0=%0d s1=%0d, required all 0",
                  bus.alu_op, bus.alu_reg_val, bus.alu_stack0, bus.alu_stack1);
      end else pass_cnt++;
   endtask

   task automatic test_push();
      do_cmd(KIND_PUSH, 3'd0, 8'd34);
      total_cnt++;
      if ((r_rdy !== 1'b1) || (r_lat != 1) || (r_err !== 1'b0) || (r_cleared !== 1'b1)) begin
         $display("FAIL push34: rdy=%b lat=%0d err=%b clr=%b, required 1/1/0/1", r_rdy, r_lat, r_err, r_cleared);
      end else pass_cnt++;
      do_cmd(KIND_PUSH, 3'd0, 8'd76);
      total_cnt++;
      if ((r_lat != 1) || (r_err !== 1'b0) || (r_data !== 8'd0)) begin
         $display("FAIL push76: lat=%0d err=%b data=%0d, required 1/0/0", r_lat, r_err, r_data);
      end else pass_cnt++;
      total_cnt++;
      if (bus.depth !== 4'd2) $display("FAIL push_depth: depth=%0d, required 2", bus.depth);
      else pass_cnt++;
   endtask

   task automatic test_exec_add();
      do_cmd(KIND_EXEC, OP_ADD, 8'd0);
      total_cnt++;
      if ((s_s0 !== 8'd76) || (s_s1 !== 8'd34) || (s_op !== OP_ADD)) begin
         $display("FAIL add_alu_in: s0=%0d s1=%0d op=%0d, required 76/34/0", s_s0, s_s1, s_op);
      end else pass_cnt++;
      total_cnt++;
      if ((r_lat != 3) || (r_data !== 8'd110) || (r_err !== 1'b0) || (r_branch !== 1'b0)
          || (r_cleared !== 1'b1) || (bus.depth !== 4'd2)) begin
         $display("FAIL add_rsp: lat=%0d data=%0d err=%b br=%b clr=%b depth=%0d, required 3/110/0/0/1/2",
                  r_lat, r_data, r_err, r_branch, r_cleared, bus.depth);
      end else pass_cnt++;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      total_cnt++;
      if ((r_lat != 1) || (r_data !== 8'd110) || (r_err !== 1'b0)) begin
         $display("FAIL add_pop1: lat=%0d data=%0d err=%b, required 1/110/0", r_lat, r_data, r_err);
      end else pass_cnt++;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      total_cnt++;
      if ((r_data !== 8'd34) || (bus.depth !== 4'd0)) begin
         $display("FAIL add_pop2: data=%0d depth=%0d, required 34/0", r_data, bus.depth);
      end else pass_cnt++;
   endtask

   task automatic test_branch();
      do_cmd(KIND_PUSH, 3'd0, 8'd50);
      do_cmd(KIND_PUSH, 3'd0, 8'd30);
      do_cmd(KIND_EXEC, OP_BLT, 8'd0);
      total_cnt++;
      if ((r_branch !== 1'b1) || (r_data !== 8'd80) || (r_lat != 3)) begin
         $display("FAIL blt_taken: br=%b data=%0d lat=%0d, required 1/80/3", r_branch, r_data, r_lat);
      end else pass_cnt++;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      do_cmd(KIND_POP, 3'd0, 8'd0);
      total_cnt++;
      if ((r_data !== 8'd50) || (bus.depth !== 4'd0)) begin
         $display("FAIL blt_next_kept: data=%0d depth=%0d, required 50/0", r_data, bus.depth);
      end else pass_cnt++;
      do_cmd(KIND_PUSH, 3'd0, 8'd30);
      do_cmd(KIND_PUSH, 3'd0, 8'd50);
      do_cmd(KIND_EXEC, OP_BLT, 8'd0);
      total_cnt++;
      if ((r_branch !== 1'b0) || (r_data !== 8'd80)) begin
         $display("FAIL blt_not_taken: br=%b data=%0d, required 0/80", r_branch, r_data);
      end else pass_cnt++;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      do_cmd(KIND_POP, 3'd0, 8'd0);
      // Stub branch is high here, but only op 001 may report it.
      do_cmd(KIND_PUSH, 3'd0, 8'd50);
      do_cmd(KIND_PUSH, 3'd0, 8'd30);
      do_cmd(KIND_EXEC, OP_ADD, 8'd0);
      total_cnt++;
      if ((r_branch !== 1'b0) || (r_data !== 8'd80)) begin
         $display("FAIL add_branch_masked: br=%b data=%0d, required 0/80", r_branch, r_data);
      end else pass_cnt++;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      do_cmd(KIND_POP, 3'd0, 8'd0);
      total_cnt++;
      if (bus.depth !== 4'd0) $display("FAIL branch_clear_depth: depth=%0d, required 0", bus.depth);
      else pass_cnt++;
   endtask

   task automatic test_reg_only();
      do_cmd(KIND_EXEC, OP_LDI, 8'd10);
      total_cnt++;
      if ((s_rv !== 8'd10) || (s_op !== OP_LDI) || (s_s0 !== 8'd30) || (s_s1 !== 8'd50)) begin
         $display("FAIL ldi_alu_in: rv=%0d op=%0d s0=%0d s1=%0d, required 10/2/30/50", s_rv, s_op, s_s0, s_s1);
      end else pass_cnt++;
      total_cnt++;
      if ((r_lat != 3) || (r_err !== 1'b0) || (r_data !== 8'd80) || (bus.depth !== 4'd0)) begin
         $display("FAIL ldi_rsp: lat=%0d err=%b data=%0d depth=%0d, required 3/0/80/0",
                  r_lat, r_err, r_data, bus.depth);
      end else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [7:0] exp;
      do_cmd(KIND_POP, 3'd0, 8'd0);
      total_cnt++;
      if ((r_lat != 1) || (r_err !== 1'b1) || (r_data !== 8'd0) || (bus.depth !== 4'd0)) begin
         $display("FAIL pop_empty: lat=%0d err=%b data=%0d depth=%0d, required 1/1/0/0",
                  r_lat, r_err, r_data, bus.depth);
      end else pass_cnt++;
      for (int i = 1; i <= 9; i++) begin
         do_cmd(KIND_PUSH, 3'd0, 8'(i));
         total_cnt++;
         if ((r_lat != 1) || (r_err !== ((i == 9) ? 1'b1 : 1'b0))) begin
            $display("FAIL push_fill%0d: lat=%0d err=%b, required 1/%0d", i, r_lat, r_err, (i == 9));
         end else pass_cnt++;
      end
      total_cnt++;
      if (bus.depth !== 4'd8) $display("FAIL full_depth: depth=%0d, required 8", bus.depth);
      else pass_cnt++;
      for (int i = 8; i >= 2; i--) begin
         do_cmd(KIND_POP, 3'd0, 8'd0);
         exp = 8'(i);
         total_cnt++;
         if ((r_data !== exp) || (r_err !== 1'b0)) begin
            $display("FAIL pop_drain%0d: data=%0d err=%b, required %0d/0", i, r_data, r_err, exp);
         end else pass_cnt++;
      end
      do_cmd(KIND_EXEC, OP_XOR, 8'h55);
      total_cnt++;
      if ((r_lat != 1) || (r_err !== 1'b1) || (r_data !== 8'd0) || (bus.depth !== 4'd1)) begin
         $display("FAIL exec_underflow: lat=%0d err=%b data=%0d depth=%0d, required 1/1/0/1",
                  r_lat, r_err, r_data, bus.depth);
      end else pass_cnt++;
      total_cnt++;
      if ((bus.alu_op !== OP_LDI) || (bus.alu_reg_val !== 8'd10) || (bus.alu_stack0 !== 8'd30)
          || (bus.alu_stack1 !== 8'd50)) begin
         $display("FAIL exec_underflow_alu: op=%0d rv=%0d s0=%0d s1=%0d, required 2/10/30/50",
                  bus.alu_op, bus.alu_reg_val, bus.alu_stack0, bus.alu_stack1);
      end else pass_cnt++;
      do_cmd(KIND_RSVD, 3'd0, 8'd7);
      total_cnt++;
      if ((r_lat != 1) || (r_err !== 1'b1) || (bus.depth !== 4'd1)) begin
         $display("FAIL kind_rsvd: lat=%0d err=%b depth=%0d, required 1/1/1", r_lat, r_err, bus.depth);
      end else pass_cnt++;
   endtask

   task automatic test_reset_mid_exec();
      int seen;
      do_cmd(KIND_PUSH, 3'd0, 8'd5);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_kind  = KIND_EXEC;
      bus.cmd_op    = OP_ADD;
      bus.cmd_data  = 8'd0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if ((bus.alu_stack0 !== 8'd5) || (bus.cmd_ready !== 1'b0)) begin
         $display("FAIL mid_wait_state: s0=%0d ready=%b, required 5/0", bus.alu_stack0, bus.cmd_ready);
      end else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ((bus.cmd_ready !== 1'b1) || (bus.depth !== 4'd0) || (bus.rsp_valid !== 1'b0)
          || (bus.alu_stack0 !== 8'd0)) begin
         $display("FAIL mid_reset: ready=%b depth=%0d rsp_valid=%b s0=%0d, required 1/0/0/0",
                  bus.cmd_ready, bus.depth, bus.rsp_valid, bus.alu_stack0);
      end else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (bus.rsp_valid) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL dropped_rsp: rsp_valid seen %0d times, required 0", seen);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_cmd(KIND_PUSH, 3'd0, 8'd9);
      do_cmd(KIND_PUSH, 3'd0, 8'd4);
      do_cmd(KIND_EXEC, OP_BLT, 8'd0);
      total_cnt++;
      if ((r_rdy !== 1'b1) || (r_lat != 3) || (r_data !== 8'd13) || (r_branch !== 1'b1)
          || (bus.depth !== 4'd2)) begin
         $display("FAIL b2b_exec: rdy=%b lat=%0d data=%0d br=%b depth=%0d, required 1/3/13/1/2",
                  r_rdy, r_lat, r_data, r_branch, bus.depth);
      end else pass_cnt++;
   endtask

   initial begin
      pass_cnt      = 0;
      total_cnt     = 0;
      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_kind  = KIND_PUSH;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_push();
      test_exec_add();
      test_branch();
      test_reg_only();
      test_errors();
      test_reset_mid_exec();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_stack_ctrl.md
Name: alu_stack_ctrl

Overview:
Sequencer that owns the operand stack feeding the 8-bit stack ALU (ports op/reg_val/stack0/stack1 in; reg_out/stack0_out/stack1_out/branch_sig out). It accepts PUSH/POP/EXEC commands over a valid/ready handshake and presents the top two stack entries to the ALU. It waits a fixed ALU latency, writes the ALU results back onto the stack, and returns result, branch flag and error on a one-cycle response strobe. It sits between instruction decode and the ALU instance.

Parameters:
W, 8, data width of stack entries and ALU operands
DEPTH, 8, stack entries (>=2)
ALU_LAT, 1, cycles from ALU inputs stable to ALU outputs valid (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_kind  in  2  00 PUSH, 01 POP, 10 EXEC, 11 reserved
cmd_op  in  3  ALU opcode for EXEC
cmd_data  in  W  PUSH value / EXEC reg_val
rsp_valid  out  1  one-cycle completion strobe
rsp_data  out  W  POP value, EXEC alu_reg_out, else 0
rsp_branch  out  1  captured alu_branch_sig, EXEC op 001 only, else 0
rsp_err  out  1  command rejected
depth  out  $clog2(DEPTH+1)  current entry count
alu_op  out  3  to ALU op
alu_reg_val  out  W  to ALU reg_val
alu_stack0  out  W  top of stack
alu_stack1  out  W  entry below top
alu_reg_out  in  W  from ALU
alu_stack0_out  in  W  from ALU
alu_stack1_out  in  W  from ALU
alu_branch_sig  in  1  from ALU

Behaviour:
- Reset (sync, high): state IDLE, depth 0, all rsp_* 0, alu_* outputs 0, wait counter 0; storage contents don't-care. Reset mid-command drops it: no rsp_valid is issued for it.
- Stack: mem[0..DEPTH-1], top = mem[depth-1], next = mem[depth-2].
- Stack ops = 000,001,011,100,101,110 (need depth>=2). Reg-only ops = 010,111 (stack untouched).
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE; cmd_ready = (state==IDLE).
- Accept edge (IDLE & cmd_valid): latch kind/op/data.
  - PUSH: if depth<DEPTH, write mem[depth]=cmd_data, depth+1; else err. Go to DONE.
  - POP: if depth>0, rsp_data<=top, depth-1; else err, rsp_data 0. Go to DONE.
  - kind 11: err, go to DONE.
  - EXEC stack op with depth<2: err, no ALU drive, stack unchanged, go to DONE.
  - EXEC otherwise: go to ISSUE.
- ISSUE (1 cycle): register alu_op=op, alu_reg_val=cmd_data, alu_stack0=top, alu_stack1=next. Reg-only ops keep alu_stack0/1 at their previous values. Load counter=ALU_LAT.
- WAIT (ALU_LAT cycles): alu_* held stable. On the final WAIT edge, capture rsp_data=alu_reg_out and rsp_branch=alu_branch_sig&(op==001). For stack ops, also write top=alu_stack0_out and next=alu_stack1_out; depth is unchanged.
- DONE (1 cycle): rsp_valid=1; rsp_data, rsp_branch and rsp_err are valid only here and are cleared to 0 on return to IDLE.
- Latency (accept = cycle 0): PUSH/POP/error rsp_valid in cycle 1; EXEC rsp_valid in cycle ALU_LAT+2. Earliest next accept is the cycle after DONE.
- alu_* outputs hold their last values outside ISSUE/WAIT.

Decomposition:
- Package alu_ctrl_pkg: cmd_kind_t enum, ALU opcode localparams (OP_ADD=000 … OP_ABS=111), state_t enum, function uses_stack(op).
- One sub-module, op_stack: LIFO storage with push, pop and write_top2 ports, exposing top, next and depth.

Test Plan:
Bench uses an ALU stub, ALU_LAT=1: reg_out=stack0_out=stack0+stack1, stack1_out=stack1, branch_sig=(stack0<stack1).
- Reset; PUSH 34, PUSH 76 -> rsp_valid cycle 1 each, rsp_err 0, depth 2.
- EXEC 000 -> during ISSUE/WAIT alu_stack0=76, alu_stack1=34; rsp_valid cycle 3, rsp_data 110. POP -> 110, POP -> 34, depth 0.
- PUSH 50, PUSH 30, EXEC 001 -> rsp_branch 1. Clear, then PUSH 30, PUSH 50, EXEC 001 -> rsp_branch 0.
- depth 0, EXEC 010 cmd_data 10 -> rsp_err 0, alu_reg_val 10, rsp_data = stub value, depth stays 0.
- Error cases:
  - POP at depth 0 -> rsp_err 1, rsp_data 0.
  - 9 PUSHes -> 9th sets rsp_err, depth stays 8.
  - EXEC 110 at depth 1 -> rsp_err in cycle 1, alu_* unchanged.
  - kind 11 -> rsp_err.
- Assert reset during WAIT -> next cycle cmd_ready 1, depth 0, no rsp_valid for the dropped EXEC.
